// File: rtl/projectile_controller_if.sv
// Storage-side bus of the projectile controller: mode-addressed register file
// access plus the unused RAM address.
interface projectile_controller_if;
   logic [3:0] mem_mode;
   logic       mem_wren;
   logic [7:0] mem_address;
   logic [7:0] mem_data;
   logic [7:0] mem_q;

   modport master (output mem_mode, mem_wren, mem_address, mem_data, input mem_q);
   modport slave  (input mem_mode, mem_wren, mem_address, mem_data, output mem_q);
endinterface

// File: rtl/projectile_controller.sv
// Game-tick sequencer: per tank, read projectile/tank state from storage,
// advance or spawn the projectile, detect hits and write the result back.
module projectile_controller #(
   parameter int GRID_MAX = 15
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           tick,
   input  logic                           fire_1,
   input  logic                           fire_2,
   projectile_controller_if.master        bus,
   output logic                           busy,
   output logic                           done,
   output logic                           hit_1,
   output logic                           hit_2
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_CAP, S_COMPUTE, S_WR_PADDR, S_WR_PDIR, S_DONE
   } state_t;

   state_t     state, state_nxt;
   logic       tank;            // 0: tank 1 pass, 1: tank 2 pass
   logic [2:0] idx;             // read slot within the current tank's pass
   logic [1:0] fire_lat;
   logic [7:0] pdir, paddr, saddr, oaddr;
   logic [1:0] sdir;
   logic [7:0] out_addr, out_dir, nxt_addr, nxt_dir;
   logic       hit_r, nxt_hit;
   logic [8:0] p_step, s_step;

   // Returns {off_grid, next_position}; no wrap-around at the edges.
   function automatic logic [8:0] step(input logic [7:0] p, input logic [1:0] d);
      logic [3:0] x, y;
      logic       off;
      x   = p[3:0];
      y   = p[7:4];
      off = 1'b0;
      case (d)
         2'd0:    begin off = (y == 4'd0);           y = y - 4'd1; end
         2'd1:    begin off = (x == 4'(GRID_MAX));   x = x + 4'd1; end
         2'd2:    begin off = (y == 4'(GRID_MAX));   y = y + 4'd1; end
         default: begin off = (x == 4'd0);           x = x - 4'd1; end
      endcase
      return {off, y, x};
   endfunction

   // Read order: projectile dir, projectile addr, self addr, self dir, other addr.
   function automatic logic [3:0] read_mode(input logic t, input logic [2:0] i);
      case (i)
         3'd0:    return t ? 4'b1000 : 4'b0100;
         3'd1:    return t ? 4'b0111 : 4'b0011;
         3'd2:    return t ? 4'b0101 : 4'b0001;
         3'd3:    return t ? 4'b0110 : 4'b0010;
         default: return t ? 4'b0001 : 4'b0101;
      endcase
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (tick) state_nxt = S_RD;
         S_RD:       state_nxt = S_CAP;
         S_CAP:      state_nxt = (idx == 3'd4) ? S_COMPUTE : S_RD;
         S_COMPUTE:  state_nxt = S_WR_PADDR;
         S_WR_PADDR: state_nxt = S_WR_PDIR;
         S_WR_PDIR:  state_nxt = tank ? S_DONE : S_RD;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.mem_mode    = 4'b0000;
      bus.mem_wren    = 1'b0;
      bus.mem_address = 8'h00;
      bus.mem_data    = 8'h00;
      busy            = (state != S_IDLE);
      done            = (state == S_DONE);
      hit_1           = 1'b0;
      hit_2           = 1'b0;
      case (state)
         S_RD, S_CAP: bus.mem_mode = read_mode(tank, idx);
         S_WR_PADDR: begin
            bus.mem_mode = tank ? 4'b0111 : 4'b0011;
            bus.mem_wren = 1'b1;
            bus.mem_data = out_addr;
            hit_1        = hit_r & ~tank;
            hit_2        = hit_r & tank;
         end
         S_WR_PDIR: begin
            bus.mem_mode = tank ? 4'b1000 : 4'b0100;
            bus.mem_wren = 1'b1;
            bus.mem_data = out_dir;
         end
         default: ;
      endcase
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      nxt_addr = paddr;
      nxt_dir  = pdir;
      nxt_hit  = 1'b0;
      p_step   = step(paddr, pdir[1:0]);
      s_step   = step(saddr, sdir);
      if (pdir[7]) begin
         if (p_step[8]) begin
            nxt_dir = {6'b0, pdir[1:0]};
         end else if (p_step[7:0] == oaddr) begin
            nxt_hit  = 1'b1;
            nxt_addr = p_step[7:0];
            nxt_dir  = {6'b0, pdir[1:0]};
         end else begin
            nxt_addr = p_step[7:0];
            nxt_dir  = {1'b1, 5'b0, pdir[1:0]};
         end
      end else if (fire_lat[tank] && !s_step[8]) begin
         nxt_addr = s_step[7:0];
         if (s_step[7:0] == oaddr) begin
            nxt_hit = 1'b1;
            nxt_dir = {6'b0, sdir};
         end else begin
            nxt_dir = {1'b1, 5'b0, sdir};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tank     <= 1'b0;
         idx      <= 3'd0;
         fire_lat <= 2'b00;
         pdir     <= 8'h00;
         paddr    <= 8'h00;
         saddr    <= 8'h00;
         sdir     <= 2'b00;
         oaddr    <= 8'h00;
         out_addr <= 8'h00;
         out_dir  <= 8'h00;
         hit_r    <= 1'b0;
      end else begin
         // A new request in the consuming cycle survives into the next pass.
         fire_lat[0] <= fire_1 | (fire_lat[0] & ~(state == S_COMPUTE && !tank));
         fire_lat[1] <= fire_2 | (fire_lat[1] & ~(state == S_COMPUTE && tank));
         case (state)
            S_IDLE: begin
               tank <= 1'b0;
               idx  <= 3'd0;
            end
            S_CAP: begin
               case (idx)
                  3'd0:    pdir  <= bus.mem_q;
                  3'd1:    paddr <= bus.mem_q;
                  3'd2:    saddr <= bus.mem_q;
                  3'd3:    sdir  <= bus.mem_q[1:0];
                  default: oaddr <= bus.mem_q;
               endcase
               idx <= idx + 3'd1;
            end
            S_COMPUTE: begin
               out_addr <= nxt_addr;
               out_dir  <= nxt_dir;
               hit_r    <= nxt_hit;
            end
            S_WR_PDIR: begin
               tank <= 1'b1;
               idx  <= 3'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_projectile_controller.sv
// Scoreboard bench for projectile_controller: a storage model answers reads,
// expected writes are queued per pass and checked by an independent monitor.
module tb_projectile_controller;

   logic clk = 1'b0;
   logic reset, tick, fire_1, fire_2;
   logic busy, done, hit_1, hit_2;

   projectile_controller_if bus ();

   projectile_controller #(.GRID_MAX(15)) dut (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .fire_1 (fire_1),
      .fire_2 (fire_2),
      .bus    (bus.master),
      .busy   (busy),
      .done   (done),
      .hit_1  (hit_1),
      .hit_2  (hit_2)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] mode;
      logic [7:0] data;
      logic       h1;
      logic       h2;
   } wr_t;

   wr_t        exp_q[$];
   wr_t        e;
   int         checks = 0;
   int         errors = 0;

   // Storage model, indexed by mode: 1 t1 addr, 2 t1 dir, 3 p1 addr, 4 p1 dir,
   // 5 t2 addr, 6 t2 dir, 7 p2 addr, 8 p2 dir.
   logic [7:0] store   [16];
   logic [7:0] pre_val [16];
   logic       pre_go;

   always @(posedge clk) begin
      if (pre_go) begin
         for (int i = 0; i < 16; i++) store[i] <= pre_val[i];
      end else if (bus.mem_wren) begin
         store[bus.mem_mode] <= bus.mem_data;
      end
      bus.mem_q <= store[bus.mem_mode];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.mem_wren) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got mode %h data %h expected none",
                     bus.mem_mode, bus.mem_data);
         end else begin
            e = exp_q.pop_front();
            check("write", {10'b0, bus.mem_mode, bus.mem_data, bus.mem_address, hit_1, hit_2},
                           {10'b0, e.mode, e.data, 8'h00, e.h1, e.h2});
         end
      end else if (hit_1 || hit_2) begin
         checks++;
         errors++;
         $display("FAIL stray_hit: got hit_1 %b hit_2 %b expected 0 0", hit_1, hit_2);
      end
   end

   task automatic push(input logic [3:0] m, input logic [7:0] d, input logic h1, input logic h2);
      exp_q.push_back('{mode: m, data: d, h1: h1, h2: h2});
   endtask

   task automatic push_pass(input logic [7:0] p1a, input logic [7:0] p1d, input logic h1,
                            input logic [7:0] p2a, input logic [7:0] p2d, input logic h2);
      push(4'b0011, p1a, h1, 1'b0);
      push(4'b0100, p1d, 1'b0, 1'b0);
      push(4'b0111, p2a, 1'b0, h2);
      push(4'b1000, p2d, 1'b0, 1'b0);
   endtask

   task automatic preload(input logic [7:0] t1a, input logic [7:0] t1d,
                          input logic [7:0] p1a, input logic [7:0] p1d,
                          input logic [7:0] t2a, input logic [7:0] t2d,
                          input logic [7:0] p2a, input logic [7:0] p2d);
      pre_val[1] = t1a; pre_val[2] = t1d; pre_val[3] = p1a; pre_val[4] = p1d;
      pre_val[5] = t2a; pre_val[6] = t2d; pre_val[7] = p2a; pre_val[8] = p2d;
      @(negedge clk) pre_go = 1'b1;
      @(negedge clk) pre_go = 1'b0;
   endtask

   task automatic pulse_fire(input int t);
      @(negedge clk);
      if (t == 1) fire_1 = 1'b1; else fire_2 = 1'b1;
      @(negedge clk);
      fire_1 = 1'b0;
      fire_2 = 1'b0;
   endtask

   // Ticks at edge 0, then runs a bounded 40-cycle window. Cycle c's inputs
   // are sampled at edge c: fire_1 in cycle f1c, extra tick in tkc, reset in rsc.
   task automatic run_pass(input string name, input int f1c, input int tkc, input int rsc,
                           input int exp_done_cyc, input int exp_done_cnt, input int exp_busy);
      int done_cyc, done_cnt, busy_cnt;
      done_cyc = 0; done_cnt = 0; busy_cnt = 0;
      @(negedge clk) tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         fire_1 = (c == f1c);
         tick   = (c == tkc);
         reset  = (c == rsc);
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         @(posedge clk);
         #1;
      end
      fire_1 = 1'b0;
      tick   = 1'b0;
      reset  = 1'b0;
      @(negedge clk);
      check({name, "_done_cycle"}, done_cyc, exp_done_cyc);
      check({name, "_done_count"}, done_cnt, exp_done_cnt);
      check({name, "_busy_cycles"}, busy_cnt, exp_busy);
      check({name, "_pending_writes"}, exp_q.size(), 0);
      check({name, "_idle_outputs"},
            {busy, done, hit_1, hit_2, bus.mem_wren, bus.mem_mode, bus.mem_data, bus.mem_address}, 0);
      exp_q.delete();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         pre_val[i] = 8'h00;
         store[i]   = 8'h00;
      end
      pre_go = 1'b0;
      reset  = 1'b1;
      tick   = 1'b0;
      fire_1 = 1'b0;
      fire_2 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            {busy, done, hit_1, hit_2, bus.mem_wren, bus.mem_mode, bus.mem_data, bus.mem_address}, 0);
      reset = 1'b0;

      // All-zero storage, no fire: every write is 8'h00.
      preload(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      push_pass(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      run_pass("zero", 0, 0, 0, 27, 1, 27);

      // Spawn from T1 at 55 facing right, then advance one step.
      preload(8'h55, 8'h01, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00);
      pulse_fire(1);
      push_pass(8'h56, 8'h81, 1'b0, 8'h00, 8'h00, 1'b0);
      run_pass("spawn", 0, 0, 0, 27, 1, 27);
      push_pass(8'h57, 8'h81, 1'b0, 8'h00, 8'h00, 1'b0);
      run_pass("advance", 0, 0, 0, 27, 1, 27);

      // Projectile at the right edge leaves the grid.
      preload(8'h55, 8'h01, 8'h5F, 8'h81, 8'hAA, 8'h00, 8'h00, 8'h00);
      push_pass(8'h5F, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0);
      run_pass("edge", 0, 0, 0, 27, 1, 27);

      // Moving projectile reaches T2.
      preload(8'h55, 8'h01, 8'h56, 8'h81, 8'h57, 8'h00, 8'h00, 8'h00);
      push_pass(8'h57, 8'h01, 1'b1, 8'h00, 8'h00, 1'b0);
      run_pass("hit1", 0, 0, 0, 27, 1, 27);

      // T2 fires point-blank at T1 directly above it.
      preload(8'h47, 8'h00, 8'h00, 8'h00, 8'h57, 8'h00, 8'h00, 8'h00);
      pulse_fire(2);
      push_pass(8'h00, 8'h00, 1'b0, 8'h47, 8'h00, 1'b1);
      run_pass("hit2", 0, 0, 0, 27, 1, 27);

      // T2 in the corner facing up: no spawn, and the request is consumed.
      preload(8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      pulse_fire(2);
      push_pass(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      run_pass("corner", 0, 0, 0, 27, 1, 27);
      preload(8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00);
      push_pass(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      run_pass("latch_clear", 0, 0, 0, 27, 1, 27);

      // Tick while busy is ignored.
      preload(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      push_pass(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      run_pass("busy_tick", 0, 10, 0, 27, 1, 27);

      // Reset in cycle 12 lets the p1 addr write through, then nothing.
      preload(8'h55, 8'h01, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00);
      pulse_fire(1);
      push(4'b0011, 8'h56, 1'b0, 1'b0);
      run_pass("abort", 0, 0, 12, 0, 0, 12);

      // Fire in T1's compute cycle misses this pass but spawns on the next.
      preload(8'h55, 8'h01, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00);
      push_pass(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      run_pass("late_fire", 11, 0, 0, 27, 1, 27);
      push_pass(8'h56, 8'h81, 1'b0, 8'h00, 8'h00, 1'b0);
      run_pass("late_spawn", 0, 0, 0, 27, 1, 27);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/projectile_controller.md
Name: projectile_controller

Overview:
Game-tick sequencer that sits directly upstream of the storage block and drives its mode/wren/address/data port. On each tick it reads both tanks' positions and directions and their projectile state. It then advances live projectiles, spawns new ones on fire requests, detects hits on the opposing tank and writes the results back. The board is a 16x16 grid; a position byte is {y[3:0], x[3:0]}.

Parameters:
GRID_MAX, 15, highest x/y coordinate; the edge test for leaving the grid.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tick  input  1  one-cycle game-tick strobe; starts one update pass
fire_1  input  1  tank 1 fire request pulse
fire_2  input  1  tank 2 fire request pulse
mem_q  input  8  read data from storage
mem_mode  output  4  storage mode (0011/0100 p1 addr/dir, 0111/1000 p2 addr/dir, 0001/0010 t1 addr/dir, 0101/0110 t2 addr/dir)
mem_wren  output  1  storage write enable
mem_address  output  8  RAM address; always 8'h00 (RAM mode unused)
mem_data  output  8  write data to storage
busy  output  1  high while a pass is in progress
done  output  1  one-cycle pulse when a pass completes
hit_1  output  1  one-cycle pulse: tank 1 projectile hit tank 2
hit_2  output  1  one-cycle pulse: tank 2 projectile hit tank 1

Behaviour:
- Reset: state IDLE; every output is 0 (mem_mode 4'b0000); fire latches cleared; capture registers cleared. Reset mid-pass aborts the pass with no further writes.
- Direction byte: bits[1:0] give the direction (0 up, 1 right, 2 down, 3 left). Projectile direction bit7 = active flag; other bits are written 0.
- Storage read timing: mode is presented in an RD cycle; mem_q is sampled at the end of the following CAP cycle. mem_wren is 0 during all reads.
- Fire latch per tank: set by fire_t in any cycle, including IDLE and busy. It is cleared in that tank's COMPUTE cycle; a fire pulse arriving in that same cycle wins, and the latch stays set.
- tick is accepted only in IDLE; a tick while busy is ignored.
- Per-tank sequence, tank 1 then tank 2 (self = current tank, other = opposing tank):
  - RD/CAP projectile dir, RD/CAP projectile addr, RD/CAP self addr, RD/CAP self dir, RD/CAP other addr (10 cycles).
  - COMPUTE (1 cycle).
  - WR_PADDR (1 cycle), then WR_PDIR (1 cycle).
- Timing: the pass is 26 cycles, then DONE (1 cycle), then IDLE. If tick is sampled at edge 0, busy is high in cycles 1..27 and done pulses in cycle 27.
- Write cycles: mem_wren=1 for exactly one cycle each, with mode and data valid in that same cycle.
- step(p,d) rules:
  - up: y-1; right: x+1; down: y+1; left: x-1.
  - Off-grid if up with y==0, right with x==GRID_MAX, down with y==GRID_MAX, or left with x==0. There is no wrap-around.
- COMPUTE rules:
  - Active: n=step(paddr,pdir).
    - Off-grid: becomes inactive, addr unchanged.
    - Else if n==other addr: hit, inactive, addr=n.
    - Else: addr=n, stays active, direction unchanged.
  - Inactive with fire latch set: s=step(self addr, self dir).
    - Off-grid: no shot, stays inactive.
    - Else if s==other addr: hit, inactive, addr=s.
    - Else: active, addr=s, dir=self dir.
  - Inactive without fire: write back the values read, unchanged.
  - A fire request while the projectile is active is discarded (latch cleared).
- hit_t pulses in that tank's WR_PADDR cycle.
- Tank 2's pass uses tank 1's write-back only through storage; there is no internal forwarding.

Test Plan:
1. Reset, then tick with all storage zero and no fire -> 26 cycles of reads/writes, each write data 8'h00, done pulses in cycle 27, busy low after.
2. T1 at 8'h55 facing right, fire_1 then tick -> write p1 addr 8'h56, p1 dir 8'h81; next tick -> p1 addr 8'h57.
3. P1 active at 8'h5F moving right (8'h81) -> p1 dir written 8'h01, addr stays 8'h5F, no hit.
4. P1 at 8'h56 moving right, T2 at 8'h57 -> hit_1 pulses once, p1 addr 8'h57, p1 dir 8'h01.
5. T2 at 8'h00 facing up, fire_2 -> no spawn, p2 dir 8'h00, latch cleared; next tick with no fire -> still no spawn.
6. Tick asserted during cycle 10 of a pass is ignored (a single done); reset asserted in cycle 12 -> mem_wren 0 from the next cycle, outputs zero.
